// File: rtl/pipe_stage.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stage
// Brief    : Parametrised pipeline stage register with valid/ready handshake,
//            synchronous flush (bubble insertion) and an optional skid entry
//            that keeps in_ready registered.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_stage #(
    parameter int unsigned      WIDTH     = 64,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter bit               SKID      = 1'b1
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       count
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_main;
    logic [WIDTH-1:0] r_skid;
    logic [WIDTH-1:0] w_main_nxt;
    logic [WIDTH-1:0] w_skid_nxt;
    logic             w_accept;
    logic             w_drain;

    // Outputs come straight from registers; M is RESET_VAL whenever empty.
    assign out_valid = (r_state != ST_EMPTY);
    assign out_data  = r_main;
    assign w_accept  = in_valid & in_ready;
    assign w_drain   = out_valid & out_ready;

    // Occupancy derived from the state.
    always_comb begin
        count = 2'd0;
        case (r_state)
            ST_ONE:  count = 2'd1;
            ST_FULL: count = 2'd2;
            default: count = 2'd0;
        endcase
    end

    // Next-state and next-payload logic; flush overrides everything.
    always_comb begin
        w_state_nxt = r_state;
        w_main_nxt  = r_main;
        w_skid_nxt  = r_skid;
        if (flush) begin
            w_state_nxt = ST_EMPTY;
            w_main_nxt  = RESET_VAL;
            w_skid_nxt  = RESET_VAL;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_accept) begin
                        w_main_nxt  = in_data;
                        w_state_nxt = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (w_accept && w_drain) begin
                        w_main_nxt = in_data;
                    end else if (w_accept) begin
                        // Only reachable with a skid entry: downstream stalled
                        // while the registered in_ready was still high.
                        if (SKID) begin
                            w_skid_nxt  = in_data;
                            w_state_nxt = ST_FULL;
                        end
                    end else if (w_drain) begin
                        w_main_nxt  = RESET_VAL;
                        w_state_nxt = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (w_drain) begin
                        w_main_nxt  = r_skid;
                        w_skid_nxt  = RESET_VAL;
                        w_state_nxt = ST_ONE;
                    end
                end
                default: begin
                    w_state_nxt = ST_EMPTY;
                    w_main_nxt  = RESET_VAL;
                    w_skid_nxt  = RESET_VAL;
                end
            endcase
        end
    end

    // State and payload registers.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state <= ST_EMPTY;
            r_main  <= RESET_VAL;
            r_skid  <= RESET_VAL;
        end else begin
            r_state <= w_state_nxt;
            r_main  <= w_main_nxt;
            r_skid  <= w_skid_nxt;
        end
    end

    generate
        if (SKID) begin : g_skid_ready
            logic r_in_ready;
            // Registered ready: low exactly while the stage will be full.
            always_ff @(posedge CLK or negedge nRST) begin
                if (!nRST) begin
                    r_in_ready <= 1'b1;
                end else begin
                    r_in_ready <= (w_state_nxt != ST_FULL);
                end
            end
            assign in_ready = r_in_ready;
        end else begin : g_comb_ready
            // Single entry: accept when empty or when the held entry leaves.
            assign in_ready = !out_valid | out_ready;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_stage
// Brief    : Self-checking bench for pipe_stage; one SKID=1 and one SKID=0
//            instance share stimulus, each with its own scoreboard queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_stage;

    localparam int unsigned      c_WIDTH = 64;
    localparam logic [63:0]      c_RVAL  = 64'h0BAD_0BAD_0BAD_0BAD;

    logic              CLK = 1'b0;
    logic              nRST = 1'b0;
    logic              flush = 1'b0;
    logic              in_valid = 1'b0;
    logic              out_ready = 1'b0;
    logic [63:0]       in_data = '0;

    logic              ir [2];
    logic              ov [2];
    logic [63:0]       od [2];
    logic [1:0]        cnt [2];

    // Expected payloads held in each instance, oldest first.
    logic [63:0]       sb [2][$];

    int tests = 0;
    int fails = 0;

    always #5 CLK = ~CLK;

    pipe_stage #(.WIDTH(c_WIDTH), .RESET_VAL(c_RVAL), .SKID(1'b1)) u_skid (
        .CLK(CLK), .nRST(nRST), .flush(flush),
        .in_valid(in_valid), .in_ready(ir[0]), .in_data(in_data),
        .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0]),
        .count(cnt[0])
    );

    pipe_stage #(.WIDTH(c_WIDTH), .RESET_VAL(c_RVAL), .SKID(1'b0)) u_noskid (
        .CLK(CLK), .nRST(nRST), .flush(flush),
        .in_valid(in_valid), .in_ready(ir[1]), .in_data(in_data),
        .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1]),
        .count(cnt[1])
    );

    task automatic chk(input string name, input int inst,
                       input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s[inst%0d] @%0t: got %h, expected %h",
                     name, inst, $time, act, exp);
        end
    endtask

    // Monitor: every transfer the DUT presents must be the oldest expected item.
    always @(negedge CLK) begin
        if (nRST) begin
            for (int i = 0; i < 2; i++) begin
                if (ov[i] && out_ready) begin
                    if (sb[i].size() == 0) begin
                        chk("unexpected_out", i, od[i], c_RVAL ^ 64'h1);
                    end else begin
                        chk("drain_data", i, od[i], sb[i].pop_front());
                    end
                end
            end
        end
    end

    // One cycle: drive inputs, check visible state against the model, and
    // record what the upcoming edge should do to the held contents.
    task automatic cycle(input bit rst_n, input bit v, input logic [63:0] d,
                         input bit rdy, input bit fl);
        @(posedge CLK);
        #1;
        nRST      = rst_n;
        in_valid  = v;
        in_data   = d;
        out_ready = rdy;
        flush     = fl;
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) sb[i].delete();
        end
        #1;
        for (int i = 0; i < 2; i++) begin
            int          n;
            bit          exp_rdy;
            bit          drn;
            logic [63:0] exp_data;
            n        = sb[i].size();
            exp_rdy  = (i == 0) ? (n < 2) : ((n == 0) || rdy);
            exp_data = (n > 0) ? sb[i][0] : c_RVAL;
            chk("in_ready",  i, {63'd0, ir[i]},  {63'd0, exp_rdy});
            chk("out_valid", i, {63'd0, ov[i]},  {63'd0, (n > 0)});
            chk("out_data",  i, od[i],           exp_data);
            chk("count",     i, {62'd0, cnt[i]}, 64'(n));
            if (rst_n) begin
                drn = (n > 0) && rdy;
                if (fl) begin
                    // Only the item the consumer takes this cycle survives.
                    if (drn) begin
                        while (sb[i].size() > 1) void'(sb[i].pop_back());
                    end else begin
                        sb[i].delete();
                    end
                end else if (v && exp_rdy) begin
                    sb[i].push_back(d);
                end
            end
        end
    endtask

    initial begin
        // Reset held with a live input: nothing may be captured.
        for (int k = 0; k < 3; k++) cycle(1'b0, 1'b1, 64'hDEAD, 1'b1, 1'b0);
        // Release: 0xDEAD accepted on the first edge with nRST high.
        cycle(1'b1, 1'b1, 64'hDEAD, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 64'h0,    1'b1, 1'b0);
        cycle(1'b1, 1'b0, 64'h0,    1'b1, 1'b0);

        // Back-to-back streaming 1..10.
        for (int k = 1; k <= 10; k++) cycle(1'b1, 1'b1, 64'(k), 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 64'h0, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 64'h0, 1'b1, 1'b0);

        // Stall with skid absorption, then release.
        cycle(1'b1, 1'b1, 64'd1, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 64'd2, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 64'd3, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 64'd3, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 64'd3, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 64'd0, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 64'd0, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 64'd0, 1'b1, 1'b0);

        // Fill with 5,6 then flush while offering 7.
        cycle(1'b1, 1'b1, 64'd5, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 64'd6, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 64'd7, 1'b0, 1'b1);
        cycle(1'b1, 1'b0, 64'd0, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 64'd0, 1'b1, 1'b0);

        // Flush coinciding with the drain of 9.
        cycle(1'b1, 1'b1, 64'd9, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 64'd0, 1'b1, 1'b1);
        cycle(1'b1, 1'b0, 64'd0, 1'b1, 1'b0);

        // Single-entry replace-in-place: 3 held, stall, then 4 replaces it.
        cycle(1'b1, 1'b1, 64'd3, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 64'd4, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 64'd4, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 64'd0, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 64'd0, 1'b1, 1'b0);

        // Randomised traffic including flushes and mid-stream async resets.
        for (int k = 0; k < 3000; k++) begin
            bit          rn;
            bit          v;
            bit          r;
            bit          f;
            logic [63:0] d;
            rn = ($urandom_range(0, 199) != 0);
            v  = ($urandom_range(0, 3) != 0);
            r  = ($urandom_range(0, 9) < 6);
            f  = ($urandom_range(0, 19) == 0);
            d  = {$urandom, $urandom};
            cycle(rn, v, d, r, f);
        end

        // Drain whatever remains.
        for (int k = 0; k < 4; k++) cycle(1'b1, 1'b0, 64'd0, 1'b1, 1'b0);
        for (int i = 0; i < 2; i++) begin
            chk("final_empty", i, 64'(sb[i].size()), 64'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
